// File: rtl/tdl_therm2onehot_if.sv
// rtl/tdl_therm2onehot_if.sv - one-hot hit word bundle from the delay-line front end
interface tdl_therm2onehot_if #(
   parameter int N_TAPS = 195
);
   logic [N_TAPS-1:0] one_hot;
   logic              one_hot_valid;
   logic              overflow;
   logic              multi_edge;

   modport master (
      output one_hot,
      output one_hot_valid,
      output overflow,
      output multi_edge
   );

   modport slave (
      input one_hot,
      input one_hot_valid,
      input overflow,
      input multi_edge
   );
endinterface

// File: rtl/tdl_therm2onehot.sv
// rtl/tdl_therm2onehot.sv - delay-line sampler, bubble corrector and one-hot hit extractor
module tdl_therm2onehot #(
   parameter int N_TAPS      = 195,
   parameter int SYNC_STAGES = 2,
   parameter int DEAD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [N_TAPS-1:0]     taps,
   tdl_therm2onehot_if.master    hit,
   output logic                  busy,
   output logic [15:0]           hit_count
);

   localparam int CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_REARM = 2'd2
   } state_t;

   logic [N_TAPS-1:0] sync_q [SYNC_STAGES];
   logic [N_TAPS-1:0] s_last;
   logic [N_TAPS-1:0] s_dn;
   logic [N_TAPS-1:0] s_up;
   logic [N_TAPS-1:0] c_nxt;
   logic [N_TAPS-1:0] c_q;
   logic              c0_prev;
   logic [N_TAPS-1:0] edge_vec;
   logic [N_TAPS-1:0] oh_sel;
   logic              multi_sel;
   logic              seen;
   logic              all_ones;
   logic              hit_det;
   logic              emit;
   state_t            state_q;
   state_t            state_nxt;
   logic [CW-1:0]     dead_cnt_q;
   logic [CW-1:0]     dead_cnt_nxt;

   // Resynchronise the raw tap sample through SYNC_STAGES flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= taps;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // Three-tap majority vote; below tap 0 mirrors tap 0, above the top tap is empty.
   assign s_last = sync_q[SYNC_STAGES-1];
   assign s_dn   = {s_last[N_TAPS-2:0], s_last[0]};
   assign s_up   = {1'b0, s_last[N_TAPS-1:1]};
   assign c_nxt  = (s_dn & s_last) | (s_dn & s_up) | (s_last & s_up);

   // Register the corrected code and remember last cycle's line-input bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= '0;
         c0_prev <= 1'b0;
      end else begin
         c_q     <= c_nxt;
         c0_prev <= c_q[0];
      end
   end

   assign edge_vec = c_q & ~{1'b0, c_q[N_TAPS-1:1]};
   assign all_ones = &c_q;

   // Keep only the highest 1->0 transition and flag when more than one exists.
   always_comb begin
      oh_sel    = '0;
      multi_sel = 1'b0;
      seen      = 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
         if (edge_vec[i]) begin
            if (seen) multi_sel = 1'b1;
            seen      = 1'b1;
            oh_sel    = '0;
            oh_sel[i] = 1'b1;
         end
      end
   end

   assign hit_det = enable & c_q[0] & ~c0_prev & (|edge_vec);

   // FSM state and dead-time counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dead_cnt_q <= '0;
      end else begin
         state_q    <= state_nxt;
         dead_cnt_q <= dead_cnt_nxt;
      end
   end

   // Next-state: accept one hit, hold off DEAD_CYCLES clocks, then wait for the line to empty.
   always_comb begin
      state_nxt    = state_q;
      dead_cnt_nxt = dead_cnt_q;
      emit         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit_det) begin
               emit         = 1'b1;
               state_nxt    = ST_DEAD;
               dead_cnt_nxt = '0;
            end
         end
         ST_DEAD: begin
            if (dead_cnt_q == CW'(DEAD_CYCLES - 1)) begin
               state_nxt    = ST_REARM;
               dead_cnt_nxt = '0;
            end else begin
               dead_cnt_nxt = dead_cnt_q + CW'(1);
            end
         end
         ST_REARM: begin
            if (!c_q[0]) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt    = ST_IDLE;
            dead_cnt_nxt = '0;
         end
      endcase
   end

   assign busy = (state_q == ST_DEAD) || (state_q == ST_REARM);

   // Output word register; everything returns to zero the cycle after a hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit.one_hot       <= '0;
         hit.one_hot_valid <= 1'b0;
         hit.overflow      <= 1'b0;
         hit.multi_edge    <= 1'b0;
         hit_count         <= '0;
      end else begin
         hit.one_hot       <= emit ? oh_sel : '0;
         hit.one_hot_valid <= emit;
         hit.overflow      <= emit & all_ones;
         hit.multi_edge    <= emit & multi_sel;
         if (emit) hit_count <= hit_count + 16'd1;
      end
   end

endmodule
